// File: rtl/counter_ctrl.sv
// counter_ctrl: button front-end for the cascaded 8-bit counter.
// Synchronises, debounces and edge-detects the run and load buttons.
// A small FSM turns the presses into a run/stop level and one-cycle load strobes.
// All outputs are registered.
// Optional feature: define AUTO_STOP_EN to stop a running counter when top_carry is sampled high.
module counter_ctrl #(
    parameter int DATA_W   = 8,
    parameter int DEBOUNCE = 16,
    parameter int DB_W     = 5
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              btn_run,
    input  logic              btn_load,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              top_carry,
    output logic              start_stop,
    output logic              load,
    output logic [DATA_W-1:0] data,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        LOAD   = 2'b10,
        UNUSED = 2'b11
    } state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    // Bit 0 carries the run button and bit 1 carries the load button.
    logic [1:0]           raw;
    logic [1:0]           s1_q, s2_q;
    logic [1:0]           db_q, db_d, dbd_q;
    logic [1:0][DB_W-1:0] cnt_q, cnt_d;
    logic [1:0]           press;
    logic                 run_press, load_press;

    state_t               state_q, state_d;
    logic                 start_stop_q, load_q;
    logic [DATA_W-1:0]    data_q;

    assign raw = {btn_load, btn_run};

    // Two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // Debounce: the level flips only after DEBOUNCE consecutive mismatching cycles
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Debounce state plus one-cycle history for rising-edge detection
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            db_q  <= '0;
            dbd_q <= '0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            dbd_q <= db_q;
            cnt_q <= cnt_d;
        end
    end

    assign press      = db_q & ~dbd_q;
    assign run_press  = press[0];
    assign load_press = press[1];

    // Next-state logic; a load press wins over a coincident run press
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (load_press) begin
                    state_d = LOAD;
                end else if (run_press) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (load_press) begin
                    state_d = LOAD;
`ifdef AUTO_STOP_EN
                end else if (top_carry) begin
                    state_d = IDLE;
`endif
                end else if (run_press) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef AUTO_STOP_EN
    logic carry_unused;
    assign carry_unused = top_carry;
`endif

    // State register; outputs are decoded from the next state so they align with state
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q      <= IDLE;
            start_stop_q <= 1'b0;
            load_q       <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            start_stop_q <= (state_d == RUN);
            load_q       <= (state_d == LOAD);
            if (state_d == LOAD) begin
                data_q <= sw_data;
            end
        end
    end

    assign start_stop = start_stop_q;
    assign load       = load_q;
    assign data       = data_q;
    assign state      = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl with DEBOUNCE=4.
// The reference model works from a window of raw button samples and a plain FSM.
module tb_counter_ctrl;

    localparam int DW  = 8;
    localparam int D   = 4;
    localparam int DBW = 3;
`ifdef AUTO_STOP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          clear = 1'b0;
    logic          btn_run = 1'b0;
    logic          btn_load = 1'b0;
    logic          top_carry = 1'b0;
    logic [DW-1:0] sw_data = '0;
    logic          start_stop, load;
    logic [DW-1:0] data;
    logic [1:0]    state;

    int vectors = 0;
    int errors  = 0;

    counter_ctrl #(.DATA_W(DW), .DEBOUNCE(D), .DB_W(DBW)) dut (
        .clock      (clock),
        .clear      (clear),
        .btn_run    (btn_run),
        .btn_load   (btn_load),
        .sw_data    (sw_data),
        .top_carry  (top_carry),
        .start_stop (start_stop),
        .load       (load),
        .data       (data),
        .state      (state)
    );

    always #5 clock = ~clock;

    logic [DW+3:0] dut_vec;
    assign dut_vec = {state, start_stop, load, data};

    // Reference model: state 0=idle, 1=run, 2=load
    int            m_state;
    int            m_nxt;
    logic [DW-1:0] m_data;
    bit            m_db_run, m_db_load, pend_run, pend_load, flip_r, flip_l;
    bit            hq_run[$];
    bit            hq_load[$];

    // A debounced level flips when the D raw samples taken 2..D+1 edges ago all differ from it
    always @(posedge clock or posedge clear) begin
        if (clear) begin
            m_state = 0; m_data = '0;
            m_db_run = 0; m_db_load = 0; pend_run = 0; pend_load = 0;
            hq_run = {}; hq_load = {};
            for (int k = 0; k < D + 2; k++) begin
                hq_run.push_back(1'b0);
                hq_load.push_back(1'b0);
            end
        end else begin
            m_nxt = m_state;
            case (m_state)
                0: if (pend_load) m_nxt = 2; else if (pend_run) m_nxt = 1;
                1: if (pend_load) m_nxt = 2; else if (AUTO && top_carry) m_nxt = 0;
                   else if (pend_run) m_nxt = 0;
                default: m_nxt = 0;
            endcase
            if (m_nxt == 2) m_data = sw_data;
            m_state = m_nxt;
            hq_run.push_back(btn_run);   void'(hq_run.pop_front());
            hq_load.push_back(btn_load); void'(hq_load.pop_front());
            flip_r = 1; flip_l = 1;
            for (int k = 0; k < D; k++) begin
                if (hq_run[k] == m_db_run)   flip_r = 0;
                if (hq_load[k] == m_db_load) flip_l = 0;
            end
            pend_run  = flip_r && !m_db_run;
            pend_load = flip_l && !m_db_load;
            if (flip_r) m_db_run  = !m_db_run;
            if (flip_l) m_db_load = !m_db_load;
        end
    end

    function automatic logic [DW+3:0] mdl_vec();
        return {2'(m_state), m_state == 1, m_state == 2, m_data};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        clear = 1'b1; #2; clear = 1'b0;
        @(negedge clock);
    endtask

    // Hold a button long enough to register, then release and let it settle
    task automatic press(input bit is_load, input int hold);
        if (is_load) btn_load = 1'b1; else btn_run = 1'b1;
        tick(hold);
        btn_run = 1'b0; btn_load = 1'b0;
        tick(hold);
    endtask

    task automatic test_reset();
        #1 clear = 1'b1;
        @(negedge clock);
        vectors++;
        if (dut_vec !== '0) begin errors++; $display("FAIL reset_init: got %h expected %h", dut_vec, 12'h000); end
        clear = 1'b0;
        tick(3);
        vectors++;
        if (dut_vec !== mdl_vec()) begin errors++; $display("FAIL reset_idle: got %h expected %h", dut_vec, mdl_vec()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sw_data = 8'h3C;
        press(1, D + 4);
        press(0, D + 4);
        vectors++;
        if (dut_vec !== {2'b01, 1'b1, 1'b0, 8'h3C})
            begin errors++; $display("FAIL mid_pre: got %h expected %h", dut_vec, {2'b01, 1'b1, 1'b0, 8'h3C}); end
        btn_run = 1'b1;
        #2 clear = 1'b1;
        #1;
        vectors++;
        if (dut_vec !== '0) begin errors++; $display("FAIL mid_async: got %h expected %h", dut_vec, 12'h000); end
        #1 clear = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clock);
            vectors++;
            if (start_stop !== (e >= D + 3))
                begin errors++; $display("FAIL held_thru_reset e%0d: got %b expected %b", e, start_stop, e >= D + 3); end
            vectors++;
            if (dut_vec !== mdl_vec()) begin errors++; $display("FAIL held_model e%0d: got %h expected %h", e, dut_vec, mdl_vec()); end
        end
        btn_run = 1'b0;
        tick(D + 4);
    endtask

    task automatic test_run_toggle();
        do_reset();
        for (int p = 0; p < 2; p++) begin
            btn_run = 1'b1;
            for (int e = 1; e <= 8; e++) begin
                @(negedge clock);
                vectors++;
                if (start_stop !== ((e >= D + 3) ^ (p == 1)))
                    begin errors++; $display("FAIL run_toggle p%0d e%0d: got %b expected %b", p, e, start_stop, (e >= D + 3) ^ (p == 1)); end
                vectors++;
                if (dut_vec !== mdl_vec()) begin errors++; $display("FAIL run_model p%0d e%0d: got %h expected %h", p, e, dut_vec, mdl_vec()); end
            end
            btn_run = 1'b0;
            tick(D + 4);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                btn_run = (c < 3);
                @(negedge clock);
                vectors++;
                if ({state, start_stop} !== 3'b000 || dut_vec !== mdl_vec())
                    begin errors++; $display("FAIL bounce r%0d c%0d: got %h expected %h", r, c, dut_vec, 12'h000); end
            end
        end
        btn_run = 1'b0;
        tick(D + 4);
        vectors++;
        if (dut_vec !== '0) begin errors++; $display("FAIL bounce_end: got %h expected %h", dut_vec, 12'h000); end
    endtask

    task automatic test_load();
        logic [DW+3:0] exp;
        do_reset();
        press(0, D + 4);
        sw_data = 8'hA5;
        btn_load = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clock);
            if (e < D + 3)       exp = {2'b01, 1'b1, 1'b0, 8'h00};
            else if (e == D + 3) exp = {2'b10, 1'b0, 1'b1, 8'hA5};
            else                 exp = {2'b00, 1'b0, 1'b0, 8'hA5};
            vectors++;
            if (dut_vec !== exp) begin errors++; $display("FAIL load e%0d: got %h expected %h", e, dut_vec, exp); end
            vectors++;
            if (dut_vec !== mdl_vec()) begin errors++; $display("FAIL load_model e%0d: got %h expected %h", e, dut_vec, mdl_vec()); end
        end
        btn_load = 1'b0;
        sw_data = 8'h11;
        tick(D + 4);
        vectors++;
        if (dut_vec !== {2'b00, 1'b0, 1'b0, 8'hA5})
            begin errors++; $display("FAIL load_hold: got %h expected %h", dut_vec, {2'b00, 1'b0, 1'b0, 8'hA5}); end
    endtask

    task automatic test_simultaneous();
        int pulses;
        pulses = 0;
        do_reset();
        sw_data = 8'h5A;
        btn_run = 1'b1; btn_load = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clock);
            if (load === 1'b1) pulses++;
            vectors++;
            if (start_stop !== 1'b0 || dut_vec !== mdl_vec())
                begin errors++; $display("FAIL simul e%0d: got %h expected %h", e, dut_vec, mdl_vec()); end
        end
        btn_run = 1'b0; btn_load = 1'b0;
        tick(D + 4);
        vectors++;
        if (pulses != 1 || state !== 2'b00)
            begin errors++; $display("FAIL simul_pulses: got %0d/%b expected 1/00", pulses, state); end
    endtask

    task automatic test_auto_stop();
        logic [DW+3:0] exp;
        do_reset();
        press(0, D + 4);
        top_carry = 1'b1;
        @(negedge clock);
        top_carry = 1'b0;
        exp = AUTO ? {2'b00, 1'b0, 1'b0, 8'h00} : {2'b01, 1'b1, 1'b0, 8'h00};
        vectors++;
        if (dut_vec !== exp) begin errors++; $display("FAIL auto_stop: got %h expected %h", dut_vec, exp); end
        tick(2);
        vectors++;
        if (dut_vec !== mdl_vec()) begin errors++; $display("FAIL auto_model: got %h expected %h", dut_vec, mdl_vec()); end
    endtask

    task automatic test_random();
        int hold_r, hold_l;
        hold_r = 0; hold_l = 0;
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            @(negedge clock);
            vectors++;
            if (dut_vec !== mdl_vec()) begin errors++; $display("FAIL random c%0d: got %h expected %h", c, dut_vec, mdl_vec()); end
            if (hold_r == 0) begin btn_run  = 1'($urandom); hold_r = $urandom_range(1, 12); end
            if (hold_l == 0) begin btn_load = ($urandom_range(0, 3) == 0); hold_l = $urandom_range(1, 12); end
            hold_r--; hold_l--;
            top_carry = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) sw_data = DW'($urandom);
            if ($urandom_range(0, 599) == 0) begin #2 clear = 1'b1; #1 clear = 1'b0; end
        end
        btn_run = 1'b0; btn_load = 1'b0; top_carry = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_run_toggle();
        test_bounce();
        test_load();
        test_simultaneous();
        test_auto_stop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Front-end control stage that drives the cascaded 8-bit counter's load, start_stop and data inputs from raw push-buttons and switches.
- Synchronises and debounces two buttons, then edge-detects them.
- A small FSM turns button presses into a run/stop level and single-cycle load strobes.
- Sits directly upstream of the counter; all outputs are registered.

Parameters:
DATA_W, 8, width of sw_data/data (matches counter cascade width)
DEBOUNCE, 16, consecutive stable cycles required before a debounced level flips (must be >= 2)
DB_W, 5, width of each debounce counter (must satisfy 2^DB_W > DEBOUNCE)

Ports:
clock  input  1  system clock, rising edge
clear  input  1  asynchronous active-high reset
btn_run  input  1  raw run/stop push-button, asynchronous, may bounce
btn_load  input  1  raw load push-button, asynchronous, may bounce
sw_data  input  DATA_W  preset value from switches, quasi-static
top_carry  input  1  carry from the most-significant counter stage (cr[1])
start_stop  output  1  count-enable level to counter
load  output  1  one-cycle load strobe to counter
data  output  DATA_W  registered preset value to counter
state  output  2  FSM state for debug/LEDs

Behaviour:
- Reset: clear=1 forces the following immediately, without waiting for a clock edge:
  - state=IDLE; start_stop=0; load=0; data=0.
  - Sync flops, debounced levels, debounce counters and edge-history flops all 0.
- Synchroniser: each button passes through 2 flops (s1, s2).
- Debounce, per button:
  - If s2 != db, cnt increments each cycle.
  - If s2 == db, cnt clears to 0.
  - When cnt == DEBOUNCE-1 and s2 != db, on the next edge db <= s2 and cnt <= 0.
  - Any mismatch shorter than DEBOUNCE cycles leaves db unchanged.
- Press pulse: press = db & ~db_d, where db_d is db delayed one cycle. It is high for exactly one cycle per debounced rising edge. Releases generate nothing.
- Latency: raw input stable from before edge 1 gives db=1 after edge DEBOUNCE+2. The FSM reacts on edge DEBOUNCE+3.
- FSM states, encoded as `state`:
  - IDLE=2'b00: on run_press, go to RUN.
  - RUN=2'b01: on run_press, go to IDLE.
  - LOAD=2'b10: unconditionally return to IDLE after 1 cycle. Presses arriving while in LOAD are discarded.
  - 2'b11: unused; recovers to IDLE on the next edge.
- Load priority: load_press in IDLE or RUN goes to LOAD. It takes priority over a simultaneous run_press, and that run_press is discarded.
- Outputs (Moore, registered, aligned with state):
  - start_stop = (state==RUN).
  - load = (state==LOAD).
- data register: captures sw_data on the edge that enters LOAD and holds it until the next LOAD or reset. It is stable whenever load=1.
- After LOAD the counter is stopped; a new run press is needed to resume.
- Reset mid-operation:
  - Any state aborts to IDLE asynchronously; a LOAD in progress is dropped.
  - A button held through reset release is seen as a fresh press after the debounce time.
- top_carry: ignored unless AUTO_STOP_EN is defined.

Optional Feature:
Macro AUTO_STOP_EN.
- Defined: in RUN, top_carry=1 sampled on an edge forces next state IDLE. start_stop drops on that edge, freezing the counter after overflow.
  - A coincident run_press also yields IDLE.
  - A coincident load_press yields LOAD.
- Not defined: top_carry is ignored entirely; the counter free-runs and wraps.

Test Plan:
- Reset: in RUN with data=0x3C, assert clear between clock edges -> start_stop=0, load=0, data=0x00, state=00 before the next edge.
- Run toggle (DEBOUNCE=4): btn_run 0->1 held -> start_stop=1 on edge 7. Release, then press again -> start_stop=0 on edge 7 of the second press.
- Bounce rejection (DEBOUNCE=4): btn_run toggling high 3 cycles / low 1 cycle, repeated 5 times, then low -> start_stop stays 0, state stays 00.
- Load: in RUN, sw_data=0xA5, press btn_load -> exactly one cycle of load=1 with data=0xA5 and start_stop=0. Then state=00, data holds 0xA5.
- Simultaneous: btn_run and btn_load raised on the same cycle from IDLE -> one load pulse, then IDLE, start_stop never 1.
- AUTO_STOP_EN: in RUN, top_carry pulsed for 1 cycle -> start_stop=0 on that edge and state=00. Without the macro -> start_stop stays 1.
